// File: rtl/key_io_pkg.sv
// Shared constants for the KEY peripheral: register map, KCTRL bit positions
// and small helpers used by the responder.
package key_io_pkg;

  localparam int DBITS = 32;
  localparam int NKEYS = 4;

  localparam logic [DBITS-1:0] ADDR_KDATA  = 32'hF0000010;
  localparam logic [DBITS-1:0] ADDR_KCTRL  = 32'hF0000110;
  localparam logic [DBITS-1:0] KCNT_OFFSET = 32'd4;

  localparam int READY_BIT = 0;
  localparam int OVR_BIT   = 1;
  localparam int IE_BIT    = 8;

  function automatic logic [DBITS-1:0] packCtrl(input logic ready, input logic overrun,
                                                input logic ie);
    logic [DBITS-1:0] r;
    r            = '0;
    r[READY_BIT] = ready;
    r[OVR_BIT]   = overrun;
    r[IE_BIT]    = ie;
    return r;
  endfunction

  function automatic logic [2:0] countOnes4(input logic [3:0] v);
    return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

endpackage

// File: rtl/key_io_responder_if.sv
// Memory-stage bus seen by the KEY peripheral: the CPU side is the master,
// the peripheral answers as slave.
interface key_io_if #(parameter int DBITS = 32);
  logic [DBITS-1:0] addrMemIn;
  logic             isLoad;
  logic             isStore;
  logic [DBITS-1:0] dataIn;
  logic [DBITS-1:0] dataOut;
  logic             hit;

  modport master (output addrMemIn, isLoad, isStore, dataIn, input dataOut, hit);
  modport slave  (input addrMemIn, isLoad, isStore, dataIn, output dataOut, hit);
endinterface

// File: rtl/key_io_responder_debouncer.sv
// One push-button: two-flop synchronizer, consecutive-mismatch counter and the
// accepted (1 = pressed) state, plus a pulse in the cycle the state flips.
module key_debouncer #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic keyPin,
  output logic keyState,
  output logic keyToggle
);

  localparam logic IDLE_LEVEL = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic        sync1;
  logic        sync2;
  logic        pressed;
  logic [19:0] count;

  assign pressed   = KEY_ACTIVE_LOW ? ~sync2 : sync2;
  // Pulse is combinational so the owner's flags update on the same edge as keyState.
  assign keyToggle = (pressed != keyState) && (count == DEBOUNCE_CYCLES - 20'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= IDLE_LEVEL;
      sync2    <= IDLE_LEVEL;
      count    <= '0;
      keyState <= 1'b0;
    end else begin
      sync1 <= keyPin;
      sync2 <= sync1;
      if (keyToggle) begin
        keyState <= ~keyState;
        count    <= '0;
      end else if (pressed != keyState) begin
        count <= count + 20'd1;
      end else begin
        count <= '0;
      end
    end
  end

endmodule

// File: rtl/key_io_responder.sv
// Memory-mapped KEY peripheral: debounced key state, ready/overrun/IE flags and irq.
// Optional press counter at ADDR_KCTRL+4 when KEY_PRESS_COUNT_EN is defined.
module key_io_responder
  import key_io_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] KEY,
  key_io_if.slave    bus,
  output logic       irq
);

  logic [NKEYS-1:0] keyState;
  logic [NKEYS-1:0] keyToggle;
  logic             ready;
  logic             overrun;
  logic             ie;
  logic             isKdata;
  logic             isKctrl;
  logic             loadOp;
  logic             storeOp;
  logic             kdataRead;
  logic             kctrlWrite;
  logic             changeEvt;
  logic [DBITS-1:0] readData;
  logic             unusedDataIn;

  for (genvar g = 0; g < NKEYS; g++) begin : gen_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .keyPin   (KEY[g]),
      .keyState (keyState[g]),
      .keyToggle(keyToggle[g])
    );
  end

  assign isKdata    = (bus.addrMemIn == ADDR_KDATA);
  assign isKctrl    = (bus.addrMemIn == ADDR_KCTRL);
  // A simultaneous load and store is handled as a store only.
  assign storeOp    = bus.isStore;
  assign loadOp     = bus.isLoad & ~bus.isStore;
  assign kdataRead  = loadOp & isKdata;
  assign kctrlWrite = storeOp & isKctrl;
  assign changeEvt  = |keyToggle;
  assign unusedDataIn = ^bus.dataIn;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready   <= 1'b0;
      overrun <= 1'b0;
      ie      <= 1'b0;
      irq     <= 1'b0;
    end else begin
      irq <= ready & ie;
      // A new event always wins over a read or a software clear.
      if (changeEvt)
        ready <= 1'b1;
      else if (kdataRead || (kctrlWrite && !bus.dataIn[READY_BIT]))
        ready <= 1'b0;
      if (changeEvt && ready && !kdataRead)
        overrun <= 1'b1;
      else if (kctrlWrite && !bus.dataIn[OVR_BIT])
        overrun <= 1'b0;
      if (kctrlWrite)
        ie <= bus.dataIn[IE_BIT];
    end
  end

`ifdef KEY_PRESS_COUNT_EN
  logic        isKcnt;
  logic [15:0] pressCount;
  logic [15:0] pressBase;

  assign isKcnt    = (bus.addrMemIn == ADDR_KCTRL + KCNT_OFFSET);
  assign pressBase = (storeOp && isKcnt) ? 16'd0 : pressCount;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pressCount <= '0;
    else
      pressCount <= pressBase + {13'b0, countOnes4(keyToggle & ~keyState)};
  end

  always_comb begin
    readData = '0;
    if (isKdata)
      readData = {{(DBITS-NKEYS){1'b0}}, keyState};
    else if (isKctrl)
      readData = packCtrl(ready, overrun, ie);
    else if (isKcnt)
      readData = {{(DBITS-16){1'b0}}, pressCount};
  end

  assign bus.hit = isKdata | isKctrl | isKcnt;
`else
  always_comb begin
    readData = '0;
    if (isKdata)
      readData = {{(DBITS-NKEYS){1'b0}}, keyState};
    else if (isKctrl)
      readData = packCtrl(ready, overrun, ie);
  end

  assign bus.hit = isKdata | isKctrl;
`endif

  assign bus.dataOut = readData;

endmodule

// File: tb/tb_key_io_responder.sv
// Self-checking bench for key_io_responder: register vector table, directed
// multi-cycle corner cases and a randomized run against a behavioural model.
module tb_key_io_responder;
  import key_io_pkg::*;

  localparam logic [19:0] NDEB      = 20'd4;
  localparam logic [31:0] ADDR_KCNT = ADDR_KCTRL + KCNT_OFFSET;
`ifdef KEY_PRESS_COUNT_EN
  localparam logic        HIT_CNT   = 1'b1;
`else
  localparam logic        HIT_CNT   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] KEY = 4'hF;
  logic       irq;

  key_io_if #(.DBITS(DBITS)) bus ();

  key_io_responder #(.DEBOUNCE_CYCLES(NDEB), .KEY_ACTIVE_LOW(1'b1)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .KEY    (KEY),
    .bus    (bus),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] expData;
    logic        expHit;
  } vec_t;
  vec_t vecs[15];

  // behavioural model state
  bit          mState[4];
  bit          mReady, mOvr, mIe, mIrq;
  logic [15:0] mCnt;
  bit          pipeQ[4][$];
  bit          winQ[4][$];
  int          hold[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idleBus();
    bus.isLoad = 1'b0; bus.isStore = 1'b0; bus.addrMemIn = '0; bus.dataIn = '0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d, output logic h);
    bus.addrMemIn = a; bus.isLoad = 1'b0; bus.isStore = 1'b0;
    #1;
    d = bus.dataOut; h = bus.hit;
  endtask

  task automatic checkReg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d; logic h;
    peek(a, d, h);
    check(name, d, exp);
  endtask

  task automatic storeReg(input logic [31:0] a, input logic [31:0] d);
    bus.addrMemIn = a; bus.dataIn = d; bus.isStore = 1'b1; bus.isLoad = 1'b0;
    @(negedge clk);
    bus.isStore = 1'b0;
  endtask

  task automatic loadReg(input logic [31:0] a, output logic [31:0] d);
    bus.addrMemIn = a; bus.isLoad = 1'b1; bus.isStore = 1'b0;
    #1;
    d = bus.dataOut;
    @(negedge clk);
    bus.isLoad = 1'b0;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    idleBus();
    waitCycles(2);
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    logic [31:0] r = '0;
    if (a == ADDR_KDATA) begin
      for (int i = 0; i < 4; i++) r[i] = mState[i];
    end else if (a == ADDR_KCTRL) begin
      r[0] = mReady; r[1] = mOvr; r[8] = mIe;
    end else if (HIT_CNT && a == ADDR_KCNT) begin
      r[15:0] = mCnt;
    end
    return r;
  endfunction

  function automatic logic modelHit(input logic [31:0] a);
    return (a == ADDR_KDATA) || (a == ADDR_KCTRL) || (HIT_CNT && a == ADDR_KCNT);
  endfunction

  task automatic modelInit();
    for (int i = 0; i < 4; i++) begin
      mState[i] = 1'b0;
      pipeQ[i].delete(); winQ[i].delete();
      pipeQ[i].push_back(1'b0); pipeQ[i].push_back(1'b0);
    end
    mReady = 0; mOvr = 0; mIe = 0; mIrq = 0; mCnt = '0;
  endtask

  // A key is accepted once the last NDEB synchronized samples all disagree with it;
  // the synchronized sample lags the pin by two clocks.
  task automatic modelStep();
    bit change = 1'b0;
    int presses = 0;
    bit st, ld, kdRead, kcWr, oldReady;
    logic [31:0] a, d;
    for (int i = 0; i < 4; i++) begin
      bit s, allDiff;
      pipeQ[i].push_back(!KEY[i]);
      s = pipeQ[i].pop_front();
      winQ[i].push_back(s);
      if (winQ[i].size() > int'(NDEB)) void'(winQ[i].pop_front());
      allDiff = (winQ[i].size() == int'(NDEB));
      foreach (winQ[i][j]) if (winQ[i][j] == mState[i]) allDiff = 1'b0;
      if (allDiff) begin
        if (!mState[i]) presses++;
        mState[i] = !mState[i];
        winQ[i].delete();
        change = 1'b1;
      end
    end
    st = bus.isStore; ld = bus.isLoad && !bus.isStore;
    a = bus.addrMemIn; d = bus.dataIn;
    kdRead = ld && (a == ADDR_KDATA);
    kcWr = st && (a == ADDR_KCTRL);
    oldReady = mReady;
    mIrq = mReady && mIe;
    if (change && oldReady && !kdRead) mOvr = 1'b1;
    else if (kcWr && !d[1]) mOvr = 1'b0;
    if (change) mReady = 1'b1;
    else if (kdRead || (kcWr && !d[0])) mReady = 1'b0;
    if (kcWr) mIe = d[8];
    if (HIT_CNT) mCnt = ((st && a == ADDR_KCNT) ? 16'd0 : mCnt) + 16'(presses);
  endtask

  initial begin
    #2000000;
    tests++; fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        h;

    vecs[0]  = '{1'b1, 1'b0, ADDR_KDATA,   32'h0,   32'h0,   1'b1};
    vecs[1]  = '{1'b1, 1'b0, ADDR_KCTRL,   32'h0,   32'h0,   1'b1};
    vecs[2]  = '{1'b0, 1'b1, ADDR_KCTRL,   32'h100, 32'h0,   1'b1};
    vecs[3]  = '{1'b1, 1'b0, ADDR_KCTRL,   32'h0,   32'h100, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, ADDR_KDATA,   32'hF,   32'h0,   1'b1};
    vecs[5]  = '{1'b1, 1'b0, ADDR_KDATA,   32'h0,   32'h0,   1'b1};
    vecs[6]  = '{1'b1, 1'b1, ADDR_KCTRL,   32'h0,   32'h100, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, ADDR_KCTRL,   32'h0,   32'h0,   1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'hF0000000, 32'h0,   32'h0,   1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'hF0000014, 32'h0,   32'h0,   1'b0};
    vecs[10] = '{1'b1, 1'b0, ADDR_KCNT,    32'h0,   32'h0,   HIT_CNT};
    vecs[11] = '{1'b0, 1'b1, ADDR_KCTRL,   32'h103, 32'h0,   1'b1};
    vecs[12] = '{1'b1, 1'b0, ADDR_KCTRL,   32'h0,   32'h100, 1'b1};
    vecs[13] = '{1'b0, 1'b1, ADDR_KCTRL,   32'h0,   32'h100, 1'b1};
    vecs[14] = '{1'b1, 1'b0, ADDR_KCTRL,   32'h0,   32'h0,   1'b1};

    idleBus();
    doReset();
    check("reset_irq", {31'b0, irq}, 32'h0);
    checkReg("reset_kctrl", ADDR_KCTRL, 32'h0);
    checkReg("reset_kdata", ADDR_KDATA, 32'h0);

    foreach (vecs[i]) begin
      bus.isLoad = vecs[i].ld; bus.isStore = vecs[i].st;
      bus.addrMemIn = vecs[i].addr; bus.dataIn = vecs[i].din;
      #1;
      check($sformatf("vec%0d_data", i), bus.dataOut, vecs[i].expData);
      check($sformatf("vec%0d_hit", i), {31'b0, bus.hit}, {31'b0, vecs[i].expHit});
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, 32'h0);
      @(negedge clk);
    end
    idleBus();

    // short glitch is rejected
    KEY[2] = 1'b0; waitCycles(3); KEY[2] = 1'b1; waitCycles(10);
    checkReg("glitch_kdata", ADDR_KDATA, 32'h0);
    checkReg("glitch_kctrl", ADDR_KCTRL, 32'h0);

    // accept latency NDEB+2
    KEY[2] = 1'b0; waitCycles(5);
    checkReg("lat_before", ADDR_KDATA, 32'h0);
    waitCycles(1);
    checkReg("lat_kdata", ADDR_KDATA, 32'h4);
    checkReg("lat_ready", ADDR_KCTRL, 32'h1);
    KEY[2] = 1'b1; waitCycles(8);
    checkReg("ovr_release", ADDR_KCTRL, 32'h3);
    storeReg(ADDR_KCTRL, 32'h0);
    checkReg("ovr_cleared", ADDR_KCTRL, 32'h0);

    // KDATA read clears ready
    KEY[0] = 1'b0; waitCycles(8);
    checkReg("press0_ready", ADDR_KCTRL, 32'h1);
    loadReg(ADDR_KDATA, d);
    check("read_kdata", d, 32'h1);
    checkReg("after_read", ADDR_KCTRL, 32'h0);
    KEY[0] = 1'b1; waitCycles(8);
    checkReg("release0_ready", ADDR_KCTRL, 32'h1);
    checkReg("release0_kdata", ADDR_KDATA, 32'h0);

    // overrun on two unread events
    storeReg(ADDR_KCTRL, 32'h0);
    KEY[1] = 1'b0; waitCycles(8);
    checkReg("ovr_first", ADDR_KCTRL, 32'h1);
    KEY[3] = 1'b0; waitCycles(8);
    checkReg("ovr_second", ADDR_KCTRL, 32'h3);
    checkReg("ovr_kdata", ADDR_KDATA, 32'hA);
    storeReg(ADDR_KCTRL, 32'h0);
    checkReg("ovr_clear", ADDR_KCTRL, 32'h0);

    // event in the same cycle as a KDATA load
    KEY[1] = 1'b1; waitCycles(8);
    checkReg("coll_pre", ADDR_KCTRL, 32'h1);
    KEY[1] = 1'b0; waitCycles(5);
    bus.addrMemIn = ADDR_KDATA; bus.isLoad = 1'b1;
    #1;
    check("coll_load_data", bus.dataOut, 32'h8);
    @(negedge clk);
    bus.isLoad = 1'b0;
    checkReg("coll_load_kctrl", ADDR_KCTRL, 32'h1);
    checkReg("coll_load_kdata", ADDR_KDATA, 32'hA);

    // event in the same cycle as an overrun-clear store
    KEY[3] = 1'b1; waitCycles(5);
    storeReg(ADDR_KCTRL, 32'h1);
    checkReg("coll_clear_kctrl", ADDR_KCTRL, 32'h3);
    checkReg("coll_clear_kdata", ADDR_KDATA, 32'h2);

    // irq follows ready & IE one cycle later
    storeReg(ADDR_KCTRL, 32'h100);
    checkReg("ie_set", ADDR_KCTRL, 32'h100);
    check("irq_idle", {31'b0, irq}, 32'h0);
    KEY[0] = 1'b0; waitCycles(6);
    checkReg("irq_ready", ADDR_KCTRL, 32'h101);
    check("irq_lag", {31'b0, irq}, 32'h0);
    waitCycles(1);
    check("irq_rise", {31'b0, irq}, 32'h1);
    storeReg(ADDR_KCTRL, 32'h0);
    check("irq_hold", {31'b0, irq}, 32'h1);
    waitCycles(1);
    check("irq_fall", {31'b0, irq}, 32'h0);
    KEY = 4'hF; waitCycles(8);
    checkReg("release_all", ADDR_KDATA, 32'h0);

`ifdef KEY_PRESS_COUNT_EN
    storeReg(ADDR_KCNT, 32'h0);
    checkReg("cnt_zero", ADDR_KCNT, 32'h0);
    for (int p = 0; p < 3; p++) begin
      KEY[0] = 1'b0; waitCycles(8);
      KEY[0] = 1'b1; waitCycles(8);
    end
    checkReg("cnt_three", ADDR_KCNT, 32'h3);
    storeReg(ADDR_KCNT, 32'hFFFF);
    checkReg("cnt_cleared", ADDR_KCNT, 32'h0);
    KEY = 4'h0; waitCycles(8);
    checkReg("cnt_multi", ADDR_KCNT, 32'h4);
    KEY = 4'hF; waitCycles(8);
`else
    peek(ADDR_KCNT, d, h);
    check("nocnt_data", d, 32'h0);
    check("nocnt_hit", {31'b0, h}, 32'h0);
`endif

    // async reset mid-run with a partial debounce in flight
    storeReg(ADDR_KCTRL, 32'h100);
    KEY[0] = 1'b0; waitCycles(8);
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    KEY = 4'hF; waitCycles(2);
    #2 reset_n = 1'b0;
    #1 check("rst_irq", {31'b0, irq}, 32'h0);
    checkReg("rst_kctrl", ADDR_KCTRL, 32'h0);
    checkReg("rst_kdata", ADDR_KDATA, 32'h0);
    waitCycles(2);
    reset_n = 1'b1;
    waitCycles(10);
    checkReg("post_rst_kdata", ADDR_KDATA, 32'h0);
    checkReg("post_rst_kctrl", ADDR_KCTRL, 32'h0);

    // key held through reset re-debounces and raises ready once
    KEY[0] = 1'b0; waitCycles(2);
    reset_n = 1'b0; waitCycles(2); reset_n = 1'b1;
    checkReg("held_after_rst", ADDR_KDATA, 32'h0);
    waitCycles(5);
    checkReg("held_before", ADDR_KDATA, 32'h0);
    waitCycles(1);
    checkReg("held_kdata", ADDR_KDATA, 32'h1);
    waitCycles(10);
    checkReg("held_kctrl", ADDR_KCTRL, 32'h1);

    // randomized run against the model
    KEY = 4'hF;
    doReset();
    modelInit();
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      int op, sel;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          KEY[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 7);
        end else begin
          hold[i]--;
        end
      end
      op  = $urandom_range(0, 9);
      sel = $urandom_range(0, 3);
      case (sel)
        0: bus.addrMemIn = ADDR_KDATA;
        1: bus.addrMemIn = ADDR_KCTRL;
        2: bus.addrMemIn = ADDR_KCNT;
        default: bus.addrMemIn = $urandom;
      endcase
      bus.isLoad  = (op < 4) || (op == 9);
      bus.isStore = (op >= 7);
      bus.dataIn  = $urandom;
      #1;
      check("rand_data", bus.dataOut, modelRead(bus.addrMemIn));
      check("rand_hit", {31'b0, bus.hit}, {31'b0, modelHit(bus.addrMemIn)});
      check("rand_irq", {31'b0, irq}, {31'b0, mIrq});
      @(posedge clk);
      modelStep();
    end
    idleBus();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_io_responder.md
Name: key_io_responder

Overview:
- Memory-mapped KEY peripheral that answers CPU data-memory loads and stores in the KEY address window.
- Synchronizes and debounces the four push-buttons, holds the stable key state and raises a sticky ready flag on every change.
- Reports overrun when a change arrives before software has read the previous one, and drives an optional interrupt line.
- Sits beside the memory unit on the pipelined datapath's memory stage and replaces raw KEY sampling.

Parameters:
- DBITS, 32, data/address bus width.
- ADDR_KDATA, 32'hF0000010, key-state register address.
- ADDR_KCTRL, 32'hF0000110, control/status register address.
- DEBOUNCE_CYCLES, 20'd500000, consecutive stable synchronized samples required before a key's state is accepted.
- KEY_ACTIVE_LOW, 1, 1 means the pin reads 0 when pressed; KDATA always reports 1 = pressed.

Ports:
- clk  input  1  system clock (PLL output).
- reset_n  input  1  asynchronous, active-low reset.
- KEY  input  4  raw push-button pins, asynchronous.
- addrMemIn  input  DBITS  memory-stage address.
- isLoad  input  1  memory-stage load strobe.
- isStore  input  1  memory-stage store strobe.
- dataIn  input  DBITS  store data.
- dataOut  output  DBITS  read data; combinational from registered state; 0 when the address misses both registers.
- hit  output  1  address equals ADDR_KDATA or ADDR_KCTRL (combinational; used by the memory unit's read mux).
- irq  output  1  registered copy of (ready & IE).

Behaviour:
- Reset (async, reset_n=0):
  - synchronizers load the inactive level (1 if KEY_ACTIVE_LOW, else 0).
  - debounce counters = 0, key state = 4'b0000.
  - ready = 0, overrun = 0, IE = 0, irq = 0.
  - dataOut depends only on address after reset.
- Synchronizer: two flops per key. Polarity is normalized after the synchronizer.
- Debounce, per key:
  - synchronized value == accepted state: counter clears to 0.
  - otherwise counter increments.
  - when counter reaches DEBOUNCE_CYCLES-1, the accepted state toggles and the counter clears.
  - latency from a stable pin change to the KDATA update is DEBOUNCE_CYCLES+2 cycles.
  - glitches shorter than DEBOUNCE_CYCLES are rejected.
  - the counter saturates-free because it clears on accept.
- Change event: any accepted-state bit toggles in a cycle; several keys in the same cycle count as one event.
- KDATA read (bits [3:0]; upper bits 0):
  - dataOut = {28'b0, state}.
  - isLoad with address hit on KDATA clears ready on that edge.
- KCTRL read:
  - bit0 = ready, bit1 = overrun, bit8 = IE, others 0.
  - a read has no side effect.
- KCTRL store:
  - bit8 writes IE.
  - bit1 written 0 clears overrun; writing 1 leaves it unchanged.
  - bit0 written 0 clears ready; writing 1 is ignored.
- KDATA store: ignored (read-only).
- Simultaneous events:
  - change event with ready=0: ready <= 1.
  - change event with ready=1 and no KDATA read that cycle: overrun <= 1.
  - change event in the same cycle as a KDATA read: ready stays 1, overrun unchanged (new event wins).
  - change event in the same cycle as a KCTRL overrun-clear with ready=1 and no read: overrun stays 1 (set wins).
- isLoad and isStore both 1: treat as store only.
- irq updates one cycle after ready or IE changes.
- Reset mid-debounce discards partial counts. Reset while a key is held: after release of reset the key re-debounces and raises ready once.

Optional Feature:
- KEY_PRESS_COUNT_EN defined:
  - adds a 16-bit press counter at ADDR_KCTRL+4.
  - counts 0→1 transitions of any accepted-state bit; a cycle with k simultaneous presses adds k.
  - wraps 16'hFFFF → 0.
  - any store to that address clears it to 0; a clear and a press in the same cycle yields k.
  - read returns {16'b0, count}; hit also covers the address.
  - reset value 0.
- Not defined: the address misses (dataOut 0, hit 0) and no counter logic exists.

Decomposition:
- Shared package key_io_pkg:
  - register address constants.
  - KCTRL bit indices (READY_BIT=0, OVR_BIT=1, IE_BIT=8).
  - the press-counter offset.
- Sub-module key_debouncer: one key with synchronizer, counter and accepted state. Outputs state and a one-cycle toggle pulse. Instantiated 4 times.
- key_io_responder holds the registers, the address decode and the irq flop.

Test Plan:
- Reset: reset_n low mid-run → irq=0. KCTRL read returns 0 and KDATA read returns 0 with KEY=4'hF and KEY_ACTIVE_LOW=1.
- Debounce (DEBOUNCE_CYCLES=4):
  - KEY[2] low for 3 cycles then high → KDATA stays 0.
  - KEY[2] held low → KDATA=4'h4 exactly 6 cycles after the pin change, ready=1.
- Read clears ready: after a KEY[0] press, load KDATA → dataOut=1, next-cycle KCTRL read=0x0. Release → ready=1, KDATA=0.
- Overrun: press KEY[1] and then KEY[3] with no read → KCTRL=0x3. Store 0x0 to KCTRL → KCTRL=0x0.
- Collision:
  - change event in the same cycle as a KDATA load → ready=1, overrun=0.
  - change event in the same cycle as an overrun-clear store with ready=1 → overrun=1.
- IRQ and option:
  - store 0x100 to KCTRL, then press → irq rises one cycle after ready.
  - with KEY_PRESS_COUNT_EN, 3 presses → count=3; store to the counter → count=0.
  - without KEY_PRESS_COUNT_EN, a read of ADDR_KCTRL+4 → hit=0 and dataOut=0.
